channel_readout_packer: RTL and testbench

- Sits directly downstream of the per-channel readout (ringbuffer plus SM1/addr_cntrl) in the digitizer.
- While a channel is in readout, it captures the 12-bit samples the channel presents and packs them densely: 4 samples into 3 16-bit words.
- It frames each readout with a 2-word header and a 2-word trailer (status plus XOR checksum).
- Words are buffered in an internal first-word-fall-through FIFO toward the SPI/host interface, with a valid/ready handshake.

---
 rtl/channel_readout_packer_if.sv | 20 ++
 rtl/channel_readout_packer.sv | 254 +++++++++++++++++++++++++
 tb/tb_channel_readout_packer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_readout_packer_if.sv
// Output word stream of the channel readout packer: FWFT FIFO head with valid/ready.
interface channel_readout_packer_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    // Packer side drives data/valid, consumer drives ready.
    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    // Consumer (SPI/host) side.
    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/channel_readout_packer.sv
// Channel readout packer: frames a channel readout as header, densely packed
// 12-bit samples (4 samples -> 3 words), trailer and XOR checksum, and buffers
// the words in a first-word-fall-through FIFO toward the host interface.
module channel_readout_packer #(
    parameter int unsigned SIZE       = 12,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   RESET_n,
    input  logic                   start,
    input  logic [3:0]             ch_id,
    input  logic [SIZE-1:0]        how_many,
    input  logic [11:0]            sample_in,
    input  logic                   sample_valid,
    input  logic                   ro_done_n,
    channel_readout_packer_if.master out_if,
    output logic                   busy,
    output logic                   overflow,
    output logic                   frame_done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_FLUSH = 3'd3,
        S_TRAIL = 3'd4,
        S_CKSUM = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [SIZE-1:0] r_cnt;
    logic [SIZE-1:0] r_acc_cnt;
    logic [1:0]      r_phase;
    logic [11:0]     r_hold;
    logic            r_trunc;
    logic            r_overflow;
    logic [15:0]     r_cksum;

    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_start;
    logic            w_accept;
    logic            w_set_trunc;
    logic            w_final;
    logic            w_push;
    logic [15:0]     w_push_data;
    logic [15:0]     w_pack_word;
    logic [15:0]     w_flush_word;
    logic            w_out_valid;
    logic            w_pop;
    logic            w_full;
    logic            w_wr_en;
    logic            w_drop;

    // The sample being accepted now is the last one the channel announced.
    assign w_final = (r_acc_cnt + SIZE'(1)) == r_cnt;

    // Packer word for the current phase, and left-aligned residual for FLUSH.
    always_comb begin
        w_pack_word  = 16'h0000;
        w_flush_word = 16'h0000;
        case (r_phase)
            2'd1: begin
                w_pack_word  = {r_hold, sample_in[11:8]};
                w_flush_word = {r_hold, 4'h0};
            end
            2'd2: begin
                w_pack_word  = {r_hold[7:0], sample_in[11:4]};
                w_flush_word = {r_hold[7:0], 8'h00};
            end
            2'd3: begin
                w_pack_word  = {r_hold[3:0], sample_in};
                w_flush_word = {r_hold[3:0], 12'h000};
            end
            default: ;
        endcase
    end

    // Frame sequencing: next state, FIFO push request and sample acceptance.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_set_trunc  = 1'b0;
        w_push       = 1'b0;
        w_push_data  = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start      = 1'b1;
                    w_push       = 1'b1;
                    w_push_data  = {8'hA5, 4'h0, ch_id};
                    w_next_state = S_HDR1;
                end
            end
            S_HDR1: begin
                w_push      = 1'b1;
                w_push_data = {4'h0, 12'(r_cnt)};
                if (r_cnt == '0) begin
                    w_next_state = S_TRAIL;
                end else begin
                    // Phase is 0 here, so an accepted sample is only held.
                    w_accept = sample_valid;
                    if (sample_valid && w_final) begin
                        w_next_state = S_FLUSH;
                    end else if (!ro_done_n) begin
                        w_set_trunc  = 1'b1;
                        w_next_state = S_FLUSH;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                w_accept = sample_valid;
                if (sample_valid && (r_phase != 2'd0)) begin
                    w_push      = 1'b1;
                    w_push_data = w_pack_word;
                end
                if (sample_valid && w_final) begin
                    w_next_state = S_FLUSH;
                end else if (!ro_done_n) begin
                    w_set_trunc  = 1'b1;
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_phase != 2'd0) begin
                    w_push      = 1'b1;
                    w_push_data = w_flush_word;
                end
                w_next_state = S_TRAIL;
            end
            S_TRAIL: begin
                w_push       = 1'b1;
                w_push_data  = {8'h5A, 6'b000000, r_trunc, r_overflow};
                w_next_state = S_CKSUM;
            end
            S_CKSUM: begin
                w_push       = 1'b1;
                w_push_data  = r_cksum;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Frame context: sample count, packer accumulator, truncation flag.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_cnt     <= '0;
            r_acc_cnt <= '0;
            r_phase   <= 2'd0;
            r_hold    <= 12'h000;
            r_trunc   <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt     <= how_many;
                r_acc_cnt <= '0;
                r_phase   <= 2'd0;
                r_trunc   <= 1'b0;
            end
            if (w_set_trunc) begin
                r_trunc <= 1'b1;
            end
            if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + SIZE'(1);
                r_phase   <= r_phase + 2'd1;
                r_hold    <= sample_in;
            end
        end
    end

    // Checksum covers every word offered to the FIFO, dropped or not.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_cksum <= 16'h0000;
        end else if (w_start) begin
            r_cksum <= w_push_data;
        end else if (w_push) begin
            r_cksum <= r_cksum ^ w_push_data;
        end
    end

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && out_if.out_ready;
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_wr_en     = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;

    // Sticky drop flag; a drop of header word 0 still counts for the new frame.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_start) begin
            r_overflow <= 1'b0;
        end
    end

    // FIFO storage; contents are only visible through the gated head word.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign out_if.out_valid = w_out_valid;
    assign out_if.out_data  = w_out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign busy             = (r_state != S_IDLE);
    assign overflow         = r_overflow;
    assign frame_done       = (r_state == S_CKSUM);

endmodule

// File: tb/tb_channel_readout_packer.sv
// Testbench for channel_readout_packer: directed and randomized frames checked
// against a bit-stream reference model of the packed frame.
module tb_channel_readout_packer;

    localparam int unsigned DEPTH = 16;

    logic        clk;
    logic        RESET_n;
    logic        start;
    logic [3:0]  ch_id;
    logic [11:0] how_many;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        ro_done_n;
    logic        busy;
    logic        overflow;
    logic        frame_done;

    channel_readout_packer_if bus ();

    channel_readout_packer #(.SIZE(12), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .RESET_n      (RESET_n),
        .start        (start),
        .ch_id        (ch_id),
        .how_many     (how_many),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .ro_done_n    (ro_done_n),
        .out_if       (bus),
        .busy         (busy),
        .overflow     (overflow),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;     // 0: never ready, 1: always ready, 2: random
    int          fd_cnt = 0;
    logic [11:0] smp[$];           // samples the model says were accepted
    logic [11:0] dir[$];           // directed sample values (empty: random)
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    logic        last_trunc;

    // Collect popped words and frame_done pulses on the quiet edge.
    always @(negedge clk) begin
        if (RESET_n) begin
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_mode == 2) bus.out_ready = 1'($urandom);
        else               bus.out_ready = (rdy_mode == 1);
    endtask

    // Reference: header, samples as one MSB-first bit stream cut into zero-padded
    // 16-bit words, trailer, then XOR of everything before it.
    task automatic build_exp(input logic [3:0] ch, input int cnt, input bit trunc, input bit no_drain);
        logic [15:0] w[$];
        bit          bq[$];
        logic [15:0] x;
        logic [11:0] c12;
        bit          ovf;
        c12 = 12'(cnt);
        w.push_back({8'hA5, 4'h0, ch});
        w.push_back({4'h0, c12});
        foreach (smp[i]) for (int b = 11; b >= 0; b--) bq.push_back(smp[i][b]);
        while (bq.size() > 0) begin
            x = 16'h0000;
            for (int b = 15; b >= 0; b--) if (bq.size() > 0) x[b] = bq.pop_front();
            w.push_back(x);
        end
        ovf = no_drain && (w.size() > DEPTH);
        w.push_back({8'h5A, 6'b000000, trunc, ovf});
        x = 16'h0000;
        foreach (w[i]) x = x ^ w[i];
        w.push_back(x);
        exp_q = w;
    endtask

    // Drive one frame. trunc_at >= 0 pulls ro_done_n low once that many samples
    // were accepted; rd_sample lets a random sample accompany that cycle.
    task automatic run_frame(input logic [3:0] ch, input int cnt, input int gap_pct,
                             input int trunc_at, input bit rd_sample, input bit no_drain);
        int acc;
        bit done;
        bit tr;
        int budget;
        smp.delete();
        got.delete();
        fd_cnt       = 0;
        start        = 1'b1;
        ch_id        = ch;
        how_many     = 12'(cnt);
        sample_valid = 1'b1;       // offered on the start cycle: must be ignored
        sample_in    = 12'($urandom);
        ro_done_n    = 1'b1;
        tick();
        start  = 1'b0;
        acc    = 0;
        tr     = 1'b0;
        budget = 0;
        if (cnt == 0) begin
            sample_valid = 1'b1;
            sample_in    = 12'($urandom);
            tick();
            tick();
        end else begin
            done = 1'b0;
            while (!done) begin
                ro_done_n = 1'b1;
                start     = ($urandom_range(0, 7) == 0);
                ch_id     = 4'($urandom);
                if (trunc_at >= 0 && acc == trunc_at) begin
                    sample_valid = rd_sample ? 1'($urandom) : 1'b0;
                    ro_done_n    = 1'b0;
                    tr           = 1'b1;
                end else begin
                    sample_valid = ($urandom_range(0, 99) >= gap_pct);
                end
                sample_in = 12'($urandom);
                if (sample_valid) begin
                    if (acc < int'(dir.size())) sample_in = dir[acc];
                    acc++;
                    smp.push_back(sample_in);
                end
                if (acc == cnt) begin
                    tr   = 1'b0;
                    done = 1'b1;
                end else if (!ro_done_n) begin
                    done = 1'b1;
                end
                tick();
                budget++;
                if (budget > 2000) begin
                    chk("frame_budget", 32'(budget), 32'd0);
                    done = 1'b1;
                end
            end
            // FLUSH and TRAIL cycles: junk samples and start pulses are ignored.
            start        = 1'b1;
            sample_valid = 1'b1;
            sample_in    = 12'($urandom);
            ro_done_n    = 1'b0;
            tick();
            tick();
        end
        start        = 1'b0;
        ro_done_n    = 1'b1;
        sample_valid = 1'b0;
        chk("frame_done_on_cksum", 32'(frame_done), 32'd1);
        chk("busy_in_cksum", 32'(busy), 32'd1);
        tick();
        chk("busy_after_cksum", 32'(busy), 32'd0);
        chk("frame_done_pulses", 32'(fd_cnt), 32'd1);
        last_trunc = tr;
        build_exp(ch, cnt, tr, no_drain);
    endtask

    // Wait for n popped words and compare them with the reference.
    task automatic wait_drain(input int n);
        int b;
        b = 0;
        while (got.size() < n && b < 400) begin
            tick();
            b++;
        end
        chk("drain_count", 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < int'(got.size()); i++)
            chk($sformatf("word%0d", i), 32'(got[i]), 32'(exp_q[i]));
        tick();
        tick();
        chk("no_extra_words", 32'(got.size()), 32'(n));
        chk("out_valid_empty", 32'(bus.out_valid), 32'd0);
        chk("out_data_empty", 32'(bus.out_data), 32'd0);
    endtask

    initial begin
        logic [15:0] k1[7];
        logic [15:0] k2[7];
        int          cnt;
        int          tat;
        k1 = '{16'hA503, 16'h0004, 16'h1234, 16'h5678, 16'h9ABC, 16'h5A00, 16'h21F7};
        k2 = '{16'hA500, 16'h0003, 16'h1112, 16'h2233, 16'h3000, 16'h5A00, 16'hFC22};

        RESET_n       = 1'b0;
        start         = 1'b0;
        ch_id         = 4'h0;
        how_many      = 12'h000;
        sample_in     = 12'h000;
        sample_valid  = 1'b0;
        ro_done_n     = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        RESET_n = 1'b1;
        tick();

        // Four samples, back to back, consumer always ready.
        rdy_mode = 1;
        dir = '{12'h123, 12'h456, 12'h789, 12'hABC};
        run_frame(4'd3, 4, 0, -1, 1'b0, 1'b0);
        wait_drain(exp_q.size());
        for (int i = 0; i < 7; i++) chk($sformatf("t1_known%0d", i), 32'(got[i]), 32'(k1[i]));

        // Three samples leave a residual nibble for FLUSH.
        dir = '{12'h111, 12'h222, 12'h333};
        run_frame(4'd0, 3, 0, -1, 1'b0, 1'b0);
        wait_drain(exp_q.size());
        for (int i = 0; i < 7; i++) chk($sformatf("t2_known%0d", i), 32'(got[i]), 32'(k2[i]));
        dir.delete();

        // Consumer stalled: FIFO fills, later words dropped, overflow sticky.
        rdy_mode = 0;
        run_frame(4'd9, 32, 0, -1, 1'b0, 1'b1);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_valid", 32'(bus.out_valid), 32'd1);
        chk("ovf_head", 32'(bus.out_data), 32'hA509);
        rdy_mode = 1;
        wait_drain(DEPTH);
        chk("ovf_sticky_after_drain", 32'(overflow), 32'd1);

        // Early end after five samples.
        run_frame(4'd5, 8, 0, 5, 1'b0, 1'b0);
        chk("trunc_clears_ovf", 32'(overflow), 32'd0);
        wait_drain(exp_q.size());
        chk("trunc_trailer", 32'(got[got.size() - 2]), 32'h5A02);
        chk("trunc_words", 32'(got.size()), 32'd8);

        // Empty readout.
        run_frame(4'd7, 0, 0, -1, 1'b0, 1'b0);
        wait_drain(exp_q.size());
        chk("empty_words", 32'(got.size()), 32'd4);
        chk("empty_hdr1", 32'(got[1]), 32'h0000);
        chk("empty_trailer", 32'(got[2]), 32'h5A00);

        // Randomized frames with gaps, truncation and a random consumer.
        rdy_mode = 2;
        for (int f = 0; f < 14; f++) begin
            cnt = $urandom_range(0, 16);
            tat = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt) : -1;
            run_frame(4'($urandom), cnt, 25, tat, 1'($urandom), 1'b0);
            chk("rand_overflow", 32'(overflow), 32'd0);
            wait_drain(exp_q.size());
        end

        // Asynchronous reset in mid-DATA with a full FIFO and overflow set.
        rdy_mode     = 0;
        got.delete();
        start        = 1'b1;
        ch_id        = 4'd2;
        how_many     = 12'd32;
        ro_done_n    = 1'b1;
        sample_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            sample_valid = 1'b1;
            sample_in    = 12'($urandom);
            tick();
        end
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        RESET_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", 32'(bus.out_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_frame_done", 32'(frame_done), 32'd0);
        sample_valid = 1'b0;
        @(negedge clk);
        RESET_n = 1'b1;
        tick();
        got.delete();

        // Clean frame after reset; run_frame pulses start while busy.
        rdy_mode = 2;
        run_frame(4'd12, 11, 10, -1, 1'b0, 1'b0);
        wait_drain(exp_q.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
